// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Purpose  : Operand forwarding and hazard detection for the 5-stage pipeline.
//            Resolves NUM_SRC decode operands against EX/MEM/WB and a
//            long-latency completion port, tracks outstanding long-latency
//            destinations in a pending scoreboard, and raises one stall for
//            load-use, scoreboard and write-after-write hazards.
// Revision : 1.0  initial release
// ============================================================================
module fwd_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int REG_BITS = 5,
  parameter int XLEN     = 32,
  parameter int MAX_OUT  = 4,
  parameter int CNT_BITS = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC*REG_BITS-1:0]     src,
  input  logic                            ex_wr,
  input  logic                            ex_load,
  input  logic [REG_BITS-1:0]             ex_dest,
  input  logic [XLEN-1:0]                 ex_val,
  input  logic                            mem_wr,
  input  logic [REG_BITS-1:0]             mem_dest,
  input  logic [XLEN-1:0]                 mem_val,
  input  logic                            wb_wr,
  input  logic [REG_BITS-1:0]             wb_dest,
  input  logic [XLEN-1:0]                 wb_val,
  input  logic                            lu_issue,
  input  logic [REG_BITS-1:0]             lu_dest,
  input  logic                            lu_done,
  input  logic [REG_BITS-1:0]             lu_done_dest,
  input  logic [XLEN-1:0]                 lu_done_val,
  output logic [NUM_SRC*XLEN-1:0]         data,
  output logic [NUM_SRC-1:0]              depends,
  output logic                            stall,
  output logic                            lu_accept,
  output logic [$clog2(MAX_OUT+1)-1:0]    pending_cnt,
  output logic [CNT_BITS-1:0]             stall_cycles
);

  localparam int NREG = 1 << REG_BITS;
  localparam int CW   = $clog2(MAX_OUT + 1);

  // Architectural state
  logic [NREG-1:0]     pending_q, pending_d;
  logic [CW-1:0]       pending_cnt_q, pending_cnt_d;
  logic [CNT_BITS-1:0] stall_cycles_q, stall_cycles_d;

  // Per-slot intermediate results
  logic [REG_BITS-1:0] src_slot [NUM_SRC];
  logic [NUM_SRC-1:0]  slot_haz;

  // Issue-side hazard terms
  logic done_eff;
  logic done_same_dest;
  logic waw_haz;
  logic full_haz;
  logic issue_haz;
  logic do_set;

  // Unpack the source indices into one entry per slot
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_slot[i] = src[i*REG_BITS +: REG_BITS];
    end
  end

  // Per-slot forwarding priority: youngest producer first, then the
  // long-latency completion, then the scoreboard.
  always_comb begin
    data     = '0;
    depends  = '0;
    slot_haz = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_slot[i] == '0) begin
        // x0 reads as zero from the register file, never forwarded
      end else if (ex_load && ex_dest == src_slot[i]) begin
        depends[i]  = 1'b1;
        slot_haz[i] = 1'b1;
      end else if (ex_wr && ex_dest == src_slot[i]) begin
        depends[i]              = 1'b1;
        data[i*XLEN +: XLEN]    = ex_val;
      end else if (mem_wr && mem_dest == src_slot[i]) begin
        depends[i]              = 1'b1;
        data[i*XLEN +: XLEN]    = mem_val;
      end else if (wb_wr && wb_dest == src_slot[i]) begin
        depends[i]              = 1'b1;
        data[i*XLEN +: XLEN]    = wb_val;
      end else if (lu_done && lu_done_dest == src_slot[i]) begin
        // Completing result is bypassed even though the bit is still set
        depends[i]              = 1'b1;
        data[i*XLEN +: XLEN]    = lu_done_val;
      end else if (pending_q[src_slot[i]]) begin
        depends[i]  = 1'b1;
        slot_haz[i] = 1'b1;
      end
    end
  end

  // Issue admission: WAW against a live pending write, or a full scoreboard
  // that is not being relieved by a completion this cycle.
  always_comb begin
    // A completion only frees a slot if it retires a genuinely pending entry;
    // this keeps the count bounded by MAX_OUT.
    done_eff       = lu_done && (lu_done_dest != '0) && pending_q[lu_done_dest];
    done_same_dest = lu_done && (lu_done_dest == lu_dest);
    waw_haz        = lu_issue && (lu_dest != '0) && pending_q[lu_dest] && !done_same_dest;
    full_haz       = lu_issue && (pending_cnt_q == CW'(MAX_OUT)) && !done_eff;
    issue_haz      = waw_haz || full_haz;
    stall          = (|slot_haz) || issue_haz;
    lu_accept      = lu_issue && !stall;
    do_set         = lu_accept && (lu_dest != '0);
  end

  // Next-state for the scoreboard and the saturating stall counter
  always_comb begin
    pending_d      = pending_q;
    pending_cnt_d  = pending_cnt_q;
    stall_cycles_d = stall_cycles_q;
    if (done_eff) begin
      pending_d[lu_done_dest] = 1'b0;
    end
    if (do_set) begin
      pending_d[lu_dest] = 1'b1;
    end
    if (do_set && !done_eff) begin
      pending_cnt_d = pending_cnt_q + CW'(1);
    end else if (!do_set && done_eff) begin
      pending_cnt_d = pending_cnt_q - CW'(1);
    end
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_BITS'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      pending_cnt_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      pending_q      <= pending_d;
      pending_cnt_q  <= pending_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pending_cnt  = pending_cnt_q;
  assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_scoreboard
// Purpose  : Directed self-checking bench for fwd_scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_fwd_scoreboard;

  localparam int NUM_SRC  = 2;
  localparam int REG_BITS = 5;
  localparam int XLEN     = 32;
  localparam int MAX_OUT  = 4;
  localparam int CNT_BITS = 32;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_SRC*REG_BITS-1:0]  src;
  logic                         ex_wr, ex_load;
  logic [REG_BITS-1:0]          ex_dest;
  logic [XLEN-1:0]              ex_val;
  logic                         mem_wr;
  logic [REG_BITS-1:0]          mem_dest;
  logic [XLEN-1:0]              mem_val;
  logic                         wb_wr;
  logic [REG_BITS-1:0]          wb_dest;
  logic [XLEN-1:0]              wb_val;
  logic                         lu_issue;
  logic [REG_BITS-1:0]          lu_dest;
  logic                         lu_done;
  logic [REG_BITS-1:0]          lu_done_dest;
  logic [XLEN-1:0]              lu_done_val;
  logic [NUM_SRC*XLEN-1:0]      data;
  logic [NUM_SRC-1:0]           depends;
  logic                         stall;
  logic                         lu_accept;
  logic [$clog2(MAX_OUT+1)-1:0] pending_cnt;
  logic [CNT_BITS-1:0]          stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  fwd_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .REG_BITS(REG_BITS),
    .XLEN    (XLEN),
    .MAX_OUT (MAX_OUT),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src         (src),
    .ex_wr       (ex_wr),
    .ex_load     (ex_load),
    .ex_dest     (ex_dest),
    .ex_val      (ex_val),
    .mem_wr      (mem_wr),
    .mem_dest    (mem_dest),
    .mem_val     (mem_val),
    .wb_wr       (wb_wr),
    .wb_dest     (wb_dest),
    .wb_val      (wb_val),
    .lu_issue    (lu_issue),
    .lu_dest     (lu_dest),
    .lu_done     (lu_done),
    .lu_done_dest(lu_done_dest),
    .lu_done_val (lu_done_val),
    .data        (data),
    .depends     (depends),
    .stall       (stall),
    .lu_accept   (lu_accept),
    .pending_cnt (pending_cnt),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then let outputs settle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src = '0;
    ex_wr = 1'b0; ex_load = 1'b0; ex_dest = '0; ex_val = '0;
    mem_wr = 1'b0; mem_dest = '0; mem_val = '0;
    wb_wr = 1'b0; wb_dest = '0; wb_val = '0;
    lu_issue = 1'b0; lu_dest = '0;
    lu_done = 1'b0; lu_done_dest = '0; lu_done_val = '0;
  endtask

  function automatic logic [NUM_SRC*REG_BITS-1:0] srcs(input logic [REG_BITS-1:0] s1,
                                                        input logic [REG_BITS-1:0] s0);
    return {s1, s0};
  endfunction

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    src = srcs(5'd4, 5'd3);
    #1;
    check("rst_cnt",    64'(pending_cnt), 64'd0);
    check("rst_stall",  64'(stall), 64'd0);
    check("rst_scyc",   64'(stall_cycles), 64'd0);
    check("rst_dep",    64'(depends), 64'b00);
    check("rst_data",   64'(data), 64'd0);

    // Forwarding priority EX > MEM > WB
    src = srcs(5'd0, 5'd5);
    ex_wr = 1'b1; ex_dest = 5'd5; ex_val = 32'h11;
    mem_wr = 1'b1; mem_dest = 5'd5; mem_val = 32'h22;
    wb_wr = 1'b1; wb_dest = 5'd5; wb_val = 32'h33;
    #1;
    check("prio_ex",    64'(data[31:0]), 64'h11);
    check("prio_ex_dep", 64'(depends), 64'b01);
    ex_wr = 1'b0;
    #1;
    check("prio_mem",   64'(data[31:0]), 64'h22);
    mem_wr = 1'b0;
    #1;
    check("prio_wb",    64'(data[31:0]), 64'h33);
    wb_wr = 1'b0;
    #1;
    check("prio_none",  64'(depends), 64'b00);

    // Register 0 is never forwarded
    src = srcs(5'd0, 5'd0);
    ex_wr = 1'b1; ex_dest = 5'd0; ex_val = 32'h77;
    #1;
    check("x0_dep",     64'(depends), 64'b00);
    check("x0_data",    64'(data), 64'd0);
    clear_inputs();

    // Load-use hazard
    src = srcs(5'd7, 5'd0);
    ex_load = 1'b1; ex_dest = 5'd7;
    #1;
    check("lu_stall",   64'(stall), 64'd1);
    check("lu_dep",     64'(depends), 64'b10);
    tick();
    check("lu_scyc1",   64'(stall_cycles), 64'd1);
    tick();
    check("lu_scyc2",   64'(stall_cycles), 64'd2);
    ex_load = 1'b0;
    mem_wr = 1'b1; mem_dest = 5'd7; mem_val = 32'hABCD;
    #1;
    check("lu_release", 64'(stall), 64'd0);
    check("lu_data1",   64'(data[63:32]), 64'hABCD);
    tick();
    check("lu_scyc_hold", 64'(stall_cycles), 64'd2);
    clear_inputs();

    // Scoreboard hazard on a long-latency destination
    lu_issue = 1'b1; lu_dest = 5'd9;
    #1;
    check("sb_accept",  64'(lu_accept), 64'd1);
    tick();
    lu_issue = 1'b0;
    src = srcs(5'd0, 5'd9);
    #1;
    check("sb_cnt1",    64'(pending_cnt), 64'd1);
    check("sb_stall",   64'(stall), 64'd1);
    tick();
    tick();
    check("sb_scyc",    64'(stall_cycles), 64'd4);
    lu_done = 1'b1; lu_done_dest = 5'd9; lu_done_val = 32'h55;
    #1;
    check("sb_bypass_stall", 64'(stall), 64'd0);
    check("sb_bypass_data",  64'(data[31:0]), 64'h55);
    check("sb_bypass_dep",   64'(depends), 64'b01);
    tick();
    lu_done = 1'b0;
    #1;
    check("sb_cnt0",    64'(pending_cnt), 64'd0);
    check("sb_nodep",   64'(depends), 64'b00);
    clear_inputs();

    // Fill the scoreboard to MAX_OUT
    for (int r = 1; r <= 4; r++) begin
      lu_issue = 1'b1; lu_dest = REG_BITS'(r);
      #1;
      check("fill_accept", 64'(lu_accept), 64'd1);
      tick();
    end
    lu_issue = 1'b0;
    #1;
    check("fill_cnt",   64'(pending_cnt), 64'd4);
    // Full: a new issue must stall
    lu_issue = 1'b1; lu_dest = 5'd6;
    #1;
    check("full_stall", 64'(stall), 64'd1);
    check("full_rej",   64'(lu_accept), 64'd0);
    tick();
    check("full_cnt",   64'(pending_cnt), 64'd4);
    check("full_scyc",  64'(stall_cycles), 64'd5);
    // Full with a simultaneous completion: accepted, count unchanged
    lu_done = 1'b1; lu_done_dest = 5'd2;
    #1;
    check("fulldone_stall", 64'(stall), 64'd0);
    check("fulldone_acc",   64'(lu_accept), 64'd1);
    tick();
    lu_done = 1'b0; lu_issue = 1'b0;
    #1;
    check("fulldone_cnt", 64'(pending_cnt), 64'd4);
    // WAW on reg 3, full condition relieved by completing reg 4
    lu_issue = 1'b1; lu_dest = 5'd3;
    lu_done = 1'b1; lu_done_dest = 5'd4;
    #1;
    check("waw_stall",  64'(stall), 64'd1);
    check("waw_rej",    64'(lu_accept), 64'd0);
    tick();
    check("waw_scyc",   64'(stall_cycles), 64'd6);
    check("waw_cnt",    64'(pending_cnt), 64'd3);

    // Same-cycle done and issue on reg 8 (pending now {1,3,6})
    lu_done = 1'b0;
    lu_issue = 1'b1; lu_dest = 5'd8;
    tick();
    check("r8_cnt4",    64'(pending_cnt), 64'd4);
    lu_done = 1'b1; lu_done_dest = 5'd8; lu_done_val = 32'h88;
    #1;
    check("r8_acc",     64'(lu_accept), 64'd1);
    tick();
    lu_issue = 1'b0; lu_done = 1'b0;
    src = srcs(5'd0, 5'd8);
    #1;
    check("r8_cnt",     64'(pending_cnt), 64'd4);
    check("r8_pending", 64'(stall), 64'd1);
    tick();
    check("r8_scyc",    64'(stall_cycles), 64'd7);

    // Reset mid-flight discards outstanding entries
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_cnt",  64'(pending_cnt), 64'd0);
    check("mid_rst_scyc", 64'(stall_cycles), 64'd0);
    src = srcs(5'd0, 5'd3);
    lu_done = 1'b1; lu_done_dest = 5'd3; lu_done_val = 32'h99;
    #1;
    check("late_stall", 64'(stall), 64'd0);
    tick();
    lu_done = 1'b0;
    #1;
    check("late_cnt",   64'(pending_cnt), 64'd0);
    check("late_dep",   64'(depends), 64'b00);
    check("late_stall2", 64'(stall), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
